// File: rtl/jt12_cen_pkg.sv
// Shared types and default constants for the jt12 clock-enable divider.
package jt12_cen_pkg;

  // Reset-stretch state: HOLD keeps rst_int asserted, RUN releases it.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

  // Default ratio-minus-1 loaded at reset (divide by 6).
  localparam int CEN_DEFDIV = 5;
  // Number of cen pulses rst_int stays high after reset release.
  localparam int CEN_RSTCYC = 3;

endpackage

// File: rtl/jt12_cen_rststretch.sv
// Reset stretcher: holds rst_int high for RSTCYC cen pulses after rst drops.
// RSTCYC is expected to be at least 1.
module jt12_cen_rststretch
  import jt12_cen_pkg::*;
#(
  parameter int RSTCYC = CEN_RSTCYC
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  output logic rst_int
);

  localparam int CW = (RSTCYC > 1) ? $clog2(RSTCYC + 1) : 1;

  rst_state_e    r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;

  // State and pulse counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state: leave HOLD on the RSTCYC-th cen; only rst returns to HOLD.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    rst_int    = 1'b0;
    case (r_state)
      HOLD: begin
        rst_int = 1'b1;
        if (cen) begin
          if (r_cnt == CW'(RSTCYC - 1)) begin
            w_state_nx = RUN;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end
      RUN:     w_state_nx = RUN;
      default: w_state_nx = HOLD;
    endcase
  end

endmodule

// File: rtl/jt12_cen_div.sv
// Programmable clock-enable divider with glitch-free ratio changes.
// Ratio updates are deferred to the period boundary so no period is ever
// truncated or stretched. Optional macro JT12_CEN_CNT_EN enables the
// 16-bit cen pulse counter; otherwise cen_cnt is tied to zero.
module jt12_cen_div
  import jt12_cen_pkg::*;
#(
  parameter int DIVW   = 3,
  parameter int DEFDIV = CEN_DEFDIV,
  parameter int RSTCYC = CEN_RSTCYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] div_sel,
  input  logic            div_we,
  output logic            div_busy,
  output logic            cen,
  output logic            cen2,
  output logic            rst_int,
  output logic [15:0]     cen_cnt
);

  logic [DIVW-1:0] r_cnt, r_cur, r_pend;
  logic            r_busy, r_cen, r_cen2, r_phase;
  logic            w_bnd;

  // Last cycle of the current period.
  assign w_bnd = (r_cnt == r_cur);

  // Period counter, ratio hand-over and registered enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cur   <= DIVW'(DEFDIV);
      r_pend  <= '0;
      r_busy  <= 1'b0;
      r_cen   <= 1'b0;
      r_cen2  <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_cen  <= w_bnd;
      r_cen2 <= w_bnd & r_phase;
      if (w_bnd) r_phase <= ~r_phase;
      if (w_bnd) begin
        r_cnt <= '0;
        // Only a ratio pending before this edge is applied; a write landing
        // on the boundary itself waits for the next one.
        if (r_busy) r_cur <= r_pend;
      end else begin
        r_cnt <= r_cnt + DIVW'(1);
      end
      if (div_we) begin
        r_pend <= div_sel;
        r_busy <= 1'b1;
      end else if (w_bnd) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign cen      = r_cen;
  assign cen2     = r_cen2;
  assign div_busy = r_busy;

`ifdef JT12_CEN_CNT_EN
  logic [15:0] r_cen_cnt;

  // Counts cen pulses; advances together with cen and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)        r_cen_cnt <= '0;
    else if (w_bnd) r_cen_cnt <= r_cen_cnt + 16'd1;
  end

  assign cen_cnt = r_cen_cnt;
`else
  assign cen_cnt = '0;
`endif

  jt12_cen_rststretch #(
    .RSTCYC (RSTCYC)
  ) u_rststretch (
    .clk     (clk),
    .rst     (rst),
    .cen     (r_cen),
    .rst_int (rst_int)
  );

endmodule

// File: tb/tb_jt12_cen_div.sv
// Directed bench for jt12_cen_div: reset defaults, reset stretch, deferred
// ratio changes, overwrite and boundary-write cases, mid-run reset and the
// cen pulse counter (live only when JT12_CEN_CNT_EN is defined).
module tb_jt12_cen_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  div_sel;
  logic        div_we;
  logic        div_busy, cen, cen2, rst_int;
  logic [15:0] cen_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jt12_cen_div dut (
    .clk      (clk),
    .rst      (rst),
    .div_sel  (div_sel),
    .div_we   (div_we),
    .div_busy (div_busy),
    .cen      (cen),
    .cen2     (cen2),
    .rst_int  (rst_int),
    .cen_cnt  (cen_cnt)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles until the next cen pulse; gives up after 64.
  task automatic wait_cen(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cen !== 1'b1 && n < 64);
  endtask

  task automatic wr(input logic [2:0] v);
    div_sel = v;
    div_we  = 1'b1;
    tick();
    div_we  = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; div_sel = '0; div_we = 1'b0;
    tick(3);
    chk("rst_cen", cen, 0);
    chk("rst_cen2", cen2, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_rstint", rst_int, 1);
    chk("rst_cencnt", cen_cnt, 0);
    rst = 1'b0;

    // Default /6 after release; cen2 on the second cen; rst_int for 3 cens.
    wait_cen(n); chk("first_cen", n, 6);
    chk("cen2_first", cen2, 0);
    chk("rstint_c1", rst_int, 1);
    wait_cen(n); chk("second_cen", n, 6);
    chk("cen2_second", cen2, 1);
    wait_cen(n); chk("third_cen", n, 6);
    chk("cen2_third", cen2, 0);
    chk("rstint_c3", rst_int, 1);
    tick();
    chk("rstint_after", rst_int, 0);
    chk("cen_after", cen, 0);

    // Mid-period write of /2: current /6 period stays intact.
    wr(3'd1);
    chk("busy_w1", div_busy, 1);
    wait_cen(n); chk("per6_intact", n, 4);
    chk("busy_clr1", div_busy, 0);
    wait_cen(n); chk("per2_a", n, 2);
    wait_cen(n); chk("per2_b", n, 2);

    // Back to /6.
    wr(3'd5);
    wait_cen(n); chk("per2_tail", n, 1);
    chk("busy_clr2", div_busy, 0);
    wait_cen(n); chk("per6_again", n, 6);

    // Overwrite while busy: 2 then 7, only /8 appears.
    wr(3'd2);
    tick();
    wr(3'd7);
    chk("busy_ovw", div_busy, 1);
    wait_cen(n); chk("per6_tail", n, 3);
    chk("busy_clr3", div_busy, 0);
    wait_cen(n); chk("per8_a", n, 8);
    wait_cen(n); chk("per8_b", n, 8);

    // Boundary write while idle: applied one period later.
    tick(7);
    wr(3'd3);
    chk("bnd_cen", cen, 1);
    chk("bnd_busy", div_busy, 1);
    wait_cen(n); chk("per8_kept", n, 8);
    chk("busy_clr4", div_busy, 0);
    wait_cen(n); chk("per4", n, 4);

    // Boundary write while busy: old pending now, new one next.
    wr(3'd1);
    tick(2);
    wr(3'd5);
    chk("bnd2_cen", cen, 1);
    chk("bnd2_busy", div_busy, 1);
    wait_cen(n); chk("per2_c", n, 2);
    chk("busy_clr5", div_busy, 0);
    wait_cen(n); chk("per6_c", n, 6);

    // Reset while busy, with a simultaneous write: all discarded.
    wr(3'd0);
    chk("busy_prerst", div_busy, 1);
    rst = 1'b1; div_sel = 3'd2; div_we = 1'b1;
    tick();
    div_we = 1'b0;
    tick();
    chk("mrst_busy", div_busy, 0);
    chk("mrst_cen", cen, 0);
    chk("mrst_rstint", rst_int, 1);
    chk("mrst_cencnt", cen_cnt, 0);
    rst = 1'b0;
    wait_cen(n); chk("mrst_p1", n, 6);
    chk("mrst_cen2_1", cen2, 0);
    wait_cen(n); chk("mrst_p2", n, 6);
    chk("mrst_cen2_2", cen2, 1);
    wait_cen(n); chk("mrst_p3", n, 6);
    chk("mrst_rstint3", rst_int, 1);
    tick();
    chk("mrst_rstint_off", rst_int, 0);

`ifdef JT12_CEN_CNT_EN
    chk("cencnt_3", cen_cnt, 3);
    wr(3'd0);
    n = 0;
    while (cen_cnt !== 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk("cencnt_ffff", cen_cnt, 16'hFFFF);
    chk("cen_div1", cen, 1);
    tick();
    chk("cencnt_wrap", cen_cnt, 16'h0000);
    chk("cen_div1_b", cen, 1);
`else
    chk("cencnt_off", cen_cnt, 0);
    wr(3'd0);
    tick(20);
    chk("cencnt_off2", cen_cnt, 0);
    chk("cen_div1", cen, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jt12_cen_div.md
JT12_CEN_DIV -- requirements
Module: jt12_cen_div

Interface
REQ-001 SHALL have parameter DIVW, default 3: width of the divide-select field; supported ratios are 1..2^DIVW.
REQ-002 SHALL have parameter DEFDIV, default 5: ratio-minus-1 loaded at reset (/6).
REQ-003 SHALL have parameter RSTCYC, default 3: number of cen pulses for which rst_int is held after reset release.
REQ-004 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port div_sel  input  DIVW: requested ratio-minus-1.
REQ-007 SHALL have port div_we  input  1: one-cycle strobe capturing div_sel as the pending ratio.
REQ-008 SHALL have port div_busy  output  1: high while a pending ratio is not yet applied.
REQ-009 SHALL have port cen  output  1: one-cycle clock-enable pulse at clk/(ratio).
REQ-010 SHALL have port cen2  output  1: one-cycle pulse on every second cen, coincident with it.
REQ-011 SHALL have port rst_int  output  1: internal reset, synchronous to the cen domain.
REQ-012 SHALL have port cen_cnt  output  16: count of cen pulses.

Function
REQ-013 SHALL keep a counter cnt that counts 0..cur_div, then returns to 0; the period is exactly cur_div+1 clk cycles.
REQ-014 SHALL register cen high for one cycle following each cycle with cnt==cur_div; cur_div=0 gives cen high every cycle.
REQ-015 SHALL toggle a phase bit on each cen; cen2 = cen AND phase==1, so the first cen after reset does not assert cen2 and the second does.
REQ-016 On div_we, SHALL store div_sel as the pending ratio and set div_busy=1 on the next cycle.
REQ-017 SHALL apply a pending ratio only in the cycle cnt==cur_div (period boundary); cnt restarts at 0 under the new ratio, and no truncated or stretched period is ever produced.
REQ-018 On a div_we while busy, SHALL overwrite the pending value; only the last written value is applied.
REQ-019 On a div_we in a boundary cycle while busy, SHALL apply the old pending value now, store the new one, and keep div_busy=1.
REQ-020 On a div_we in a boundary cycle while idle, SHALL apply it at the following boundary, not the current one.
REQ-021 SHALL implement states HOLD (rst_int=1) and RUN: HOLD->RUN after RSTCYC cen pulses; RUN->HOLD only on rst.
REQ-022 SHALL increment cen_cnt on each cen, wrapping 0xFFFF->0x0000.

Reset
REQ-023 While rst=1, on each rising edge: cnt=0, cur_div=DEFDIV, no pending ratio, div_busy=0, cen=0, cen2=0, phase=0, rst_int=1, state=HOLD, cen_cnt=0.
REQ-024 An asserted rst SHALL abort a pending ratio change and any partial period; rst overrides div_we in the same cycle.
REQ-025 rst_int SHALL fall in the cycle following the RSTCYC-th cen after rst release.

Configuration
REQ-026 Macro JT12_CEN_CNT_EN: when defined, cen_cnt SHALL be the live counter of REQ-022; when undefined, cen_cnt SHALL be constant 0 and the counter SHALL not be synthesised.

Structure
REQ-027 Package jt12_cen_pkg SHALL hold the state enum (HOLD, RUN) and default constants (DEFDIV, RSTCYC).
REQ-028 The reset-stretch counter and state machine SHALL be the sub-module jt12_cen_rststretch, driven by cen and rst.

Verification
REQ-029 Reset defaults: rst released -> cen first high 6 cycles later, then every 6 cycles; cen2 on every 12th cycle.
REQ-030 rst_int: default parameters -> rst_int=1 through the 3rd cen and 0 from the cycle after it.
REQ-031 Ratio change: div_sel=1 with div_we mid-period -> div_busy=1; the current /6 period completes intact; the next period is /2; div_busy=0 after the boundary.
REQ-032 Overwrite while busy: write 2, then 7 before the boundary -> only /8 is applied; a write on the boundary cycle is applied one period later.
REQ-033 Mid-operation reset: rst during busy -> pending ratio is discarded and the /6 default with its reset sequence restarts.
REQ-034 With JT12_CEN_CNT_EN and div_sel=0: cen_cnt reaches 0xFFFF, then 0x0000 on the next cen; without the macro, cen_cnt stays 0.
